qsort_engine: RTL and testbench
===============================

Name: qsort_engine

Overview:
- Downstream consumer of the array loader stage.
- Takes the flat K-entry array of IEEE-754-style floats (sign, M-bit exponent, N-bit mantissa) once the loader signals completion.
- Sorts the array in place, ascending, using iterative Lomuto quicksort with an explicit (lo,hi) stack.
- Presents the sorted flat array and pulses a completion flag for the next stage.

Parameters:
- N, 23, mantissa width.
- M, 8, exponent width.
- L, N+M+1, element width (sign + exponent + mantissa).
- K, 10, number of elements; legal range K >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_sort_n  input  1  reset; synchronous, active-low.
- start_sort  input  1  request to sort; normally tied to the loader's finish flag.
- Arr_in  input  L*K  unsorted array; element e occupies bits [e*L +: L].
- busy  output  1  high while a sort is in progress.
- finish_sort  output  1  one-cycle pulse when Arr_out holds the sorted result.
- Arr_out  output  L*K  working and result array, same packing as Arr_in.

Behaviour:
- Reset: one clock, synchronous, active-low. reset_sort_n low at a posedge forces:
  - state IDLE, stack pointer 0;
  - busy=0, finish_sort=0, Arr_out=0.
  - Reset mid-sort aborts immediately; no partial result is flagged.
- Element compare lt(a,b):
  - Sign-magnitude total order on the L-bit pattern.
  - Signs differ: the negative element is less, except +0 and -0 compare equal.
  - Both positive: unsigned compare of bits [L-2:0].
  - Both negative: reversed unsigned compare of bits [L-2:0].
  - NaN gets no special handling; it is ordered by bit pattern.
- Index and stack widths:
  - Indices are $clog2(K)+1 bits, so boundary checks never underflow.
  - Stack has K entries of (lo,hi).
- IDLE:
  - start_sort=1 latches Arr_in into Arr_out and sets busy=1.
  - If K>1, push (0,K-1).
  - Go to POP.
  - start_sort is ignored in every other state.
- POP:
  - Stack empty: go to DONE.
  - Otherwise pop (lo,hi), set pivot index hi, i=lo, j=lo, and go to SCAN.
- SCAN, one element per cycle:
  - j<hi: if lt(a[j],a[hi]), swap a[i] and a[j] and increment i. Increment j in both cases.
  - j==hi: go to PIVOT.
- PIVOT: swap a[i] and a[hi] (a no-op if i==hi), then go to PUSH.
- PUSH, single cycle; may push 0, 1 or 2 entries:
  - Push (lo,i-1) if i>lo+1.
  - Push (i+1,hi) if hi>i+1.
  - Go to POP.
- DONE: finish_sort=1 for exactly one cycle, busy=0, go to IDLE.
- Result hold: Arr_out holds the result until the next accepted start or reset.
- Transient contents: Arr_out contents while busy=1 are not meaningful to consumers.
- Ties: equal elements keep no particular order (the sort is not stable).
- K=1: IDLE -> POP -> DONE. finish_sort asserts 2 cycles after start is accepted; Arr_out equals Arr_in.
- Latency bound, start-accept edge to finish_sort high: at most K(K-1)/2 + 4K + 4 cycles.
- Re-start: start_sort held high through DONE starts a new sort on the IDLE cycle that follows.

Optional Feature:
- Macro: QSORT_DESCEND_EN.
- Defined: the SCAN test uses lt(a[hi],a[j]), so the result is in descending order. Latency bound unchanged.
- Undefined: ascending order as described above.

Test Plan:
- Reset: reset_sort_n=0 for 2 cycles while busy mid-sort -> busy=0, finish_sort=0, Arr_out=0, and no finish_sort pulse afterwards.
- Mixed values, K=10:
  - Input {3.0=40400000, 1.0=3F800000, -2.0=C0000000, 0, 80000000, 7F7FFFFF, FF7FFFFF, 3F000000, BF000000, 40400000}.
  - Required response: finish_sort pulses once, Arr_out ascending by lt, with FF7FFFFF first and 7F7FFFFF last.
  - The 00000000/80000000 pair is adjacent in either order; the two 40400000 entries are adjacent.
- Worst case: already-sorted input 1..10 as floats -> output unchanged; cycle count at or below the bound (89 cycles for K=10); stack never overflows.
- Reverse-sorted and all-equal inputs (all 3F800000) -> correct output; finish_sort width exactly 1 cycle.
- Start while busy: pulse start_sort with a new Arr_in mid-sort -> ignored; result corresponds to the first array.
- Parameter corners:
  - K=1 -> Arr_out=Arr_in, finish_sort 2 cycles after accept.
  - K=2, input {40000000,3F800000} -> {3F800000,40000000}.
  - With QSORT_DESCEND_EN defined, the mixed case output is exactly reversed.

Source files
------------

// File: rtl/qsort_if.sv
// Sort-engine handshake bundle: the start request and unsorted array in,
// busy/finish status and the sorted array out.
interface qsort_if #(
    parameter int L = 32,
    parameter int K = 10
);
    logic           start_sort;
    logic [L*K-1:0] Arr_in;
    logic           busy;
    logic           finish_sort;
    logic [L*K-1:0] Arr_out;

    modport master (
        output start_sort, Arr_in,
        input  busy, finish_sort, Arr_out
    );

    modport slave (
        input  start_sort, Arr_in,
        output busy, finish_sort, Arr_out
    );
endinterface

// File: rtl/qsort_engine.sv
// In-place iterative Lomuto quicksort over K sign-magnitude floats.
// Define QSORT_DESCEND_EN to produce descending order instead.
module qsort_engine #(
    parameter int N = 23,
    parameter int M = 8,
    parameter int L = N + M + 1,
    parameter int K = 10
) (
    input  logic   clk,
    input  logic   reset_sort_n,
    qsort_if.slave sif
);
    localparam int IW = $clog2(K) + 1;
    localparam int AW = (K > 1) ? $clog2(K) : 1;

    typedef logic [IW-1:0] idx_t;

    localparam idx_t ONE = idx_t'(1);
    localparam idx_t KM1 = idx_t'(K - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] SCAN  = 3'd2;
    localparam logic [2:0] PIVOT = 3'd3;
    localparam logic [2:0] PUSH  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]   state;
    logic [L-1:0] a [K];
    idx_t         stk_lo [K];
    idx_t         stk_hi [K];
    idx_t         sp, lo, hi, i, j;
    logic         busy_q, fin_q;

    // +0 and -0 are equal; negatives order by reversed magnitude
    function automatic logic lt(input logic [L-1:0] x, input logic [L-1:0] y);
        logic r;
        if (x[L-1] != y[L-1])
            r = x[L-1] && !(x[L-2:0] == '0 && y[L-2:0] == '0);
        else if (!x[L-1])
            r = x[L-2:0] < y[L-2:0];
        else
            r = x[L-2:0] > y[L-2:0];
        return r;
    endfunction

    logic [L-1:0] ai, aj, ahi;
    logic         take;
    idx_t         top;
    logic         push_l, push_r;
    idx_t         sp_r;

    assign ai   = a[i[AW-1:0]];
    assign aj   = a[j[AW-1:0]];
    assign ahi  = a[hi[AW-1:0]];
    assign top  = sp - ONE;

`ifdef QSORT_DESCEND_EN
    assign take = lt(ahi, aj);
`else
    assign take = lt(aj, ahi);
`endif

    assign push_l = i > lo + ONE;
    assign push_r = hi > i + ONE;
    assign sp_r   = push_l ? sp + ONE : sp;

    always_ff @(posedge clk) begin
        if (!reset_sort_n) begin
            state  <= IDLE;
            sp     <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
            for (int e = 0; e < K; e++) a[e] <= '0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                IDLE: if (sif.start_sort) begin
                    for (int e = 0; e < K; e++)
                        a[e] <= sif.Arr_in[e*L +: L];
                    busy_q    <= 1'b1;
                    stk_lo[0] <= '0;
                    stk_hi[0] <= KM1;
                    sp        <= (K > 1) ? ONE : '0;
                    state     <= POP;
                end
                POP: if (sp == '0) begin
                    fin_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end else begin
                    sp    <= top;
                    lo    <= stk_lo[top[AW-1:0]];
                    hi    <= stk_hi[top[AW-1:0]];
                    i     <= stk_lo[top[AW-1:0]];
                    j     <= stk_lo[top[AW-1:0]];
                    state <= SCAN;
                end
                SCAN: if (j < hi) begin
                    if (take) begin
                        a[i[AW-1:0]] <= aj;
                        a[j[AW-1:0]] <= ai;
                        i <= i + ONE;
                    end
                    j <= j + ONE;
                end else begin
                    state <= PIVOT;
                end
                PIVOT: begin
                    a[i[AW-1:0]]  <= ahi;
                    a[hi[AW-1:0]] <= ai;
                    state <= PUSH;
                end
                PUSH: begin
                    if (push_l) begin
                        stk_lo[sp[AW-1:0]] <= lo;
                        stk_hi[sp[AW-1:0]] <= i - ONE;
                    end
                    if (push_r) begin
                        stk_lo[sp_r[AW-1:0]] <= i + ONE;
                        stk_hi[sp_r[AW-1:0]] <= hi;
                    end
                    sp    <= sp + idx_t'(push_l) + idx_t'(push_r);
                    state <= POP;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [L*K-1:0] flat;

    always_comb begin
        flat = '0;
        for (int e = 0; e < K; e++) flat[e*L +: L] = a[e];
    end

    assign sif.Arr_out     = flat;
    assign sif.busy        = busy_q;
    assign sif.finish_sort = fin_q;
endmodule

// File: tb/tb_qsort_engine.sv
// Directed bench for qsort_engine: K=10 main instance plus K=1 and K=2
// corner instances; expectations follow QSORT_DESCEND_EN when defined.
module tb_qsort_engine;
    localparam int N = 23;
    localparam int M = 8;
    localparam int L = 32;
    localparam int K = 10;
`ifdef QSORT_DESCEND_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    typedef logic [31:0] vec_t [K];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qsort_if #(.L(L), .K(K)) b10();
    qsort_if #(.L(L), .K(1)) b1();
    qsort_if #(.L(L), .K(2)) b2();

    qsort_engine #(.N(N), .M(M), .K(K)) u_dut (
        .clk(clk), .reset_sort_n(rst_n), .sif(b10));
    qsort_engine #(.N(N), .M(M), .K(1)) u_k1 (
        .clk(clk), .reset_sort_n(rst_n), .sif(b1));
    qsort_engine #(.N(N), .M(M), .K(2)) u_k2 (
        .clk(clk), .reset_sort_n(rst_n), .sif(b2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [L*K-1:0] pack(input vec_t v);
        logic [L*K-1:0] f;
        for (int e = 0; e < K; e++) f[e*L +: L] = v[e];
        return f;
    endfunction

    function automatic logic [31:0] el(input int e);
        return b10.Arr_out[e*L +: L];
    endfunction

    function automatic int pos(input int p);
        return DESC ? K - 1 - p : p;
    endfunction

    // Start a K=10 sort; optionally re-pulse start with alt at cycle 5.
    task automatic sort10(input vec_t v, input vec_t alt, input bit poke,
                          input string tag, output int cyc);
        @(posedge clk); #1;
        b10.Arr_in = pack(v);
        b10.start_sort = 1'b1;
        @(posedge clk); #1;
        b10.start_sort = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, {31'd0, b10.busy}, 32'd1);
        while (!b10.finish_sort && cyc < 300) begin
            if (poke && cyc == 5) begin
                b10.Arr_in = pack(alt);
                b10.start_sort = 1'b1;
            end else begin
                b10.start_sort = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b10.start_sort = 1'b0;
        check({tag, "_done"}, {31'd0, b10.finish_sort}, 32'd1);
        check({tag, "_idle"}, {31'd0, b10.busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_width"}, {31'd0, b10.finish_sort}, 32'd0);
    endtask

    task automatic check_plain(input vec_t exp_asc, input string tag);
        for (int p = 0; p < K; p++)
            check($sformatf("%s_e%0d", tag, pos(p)), el(pos(p)), exp_asc[p]);
    endtask

    vec_t mixed, mixed_asc, seq, rev, ones;
    int   cyc, pulses;
    logic [31:0] x, y;

    initial begin
        mixed = '{32'h40400000, 32'h3F800000, 32'hC0000000, 32'h00000000,
                  32'h80000000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h3F000000,
                  32'hBF000000, 32'h40400000};
        mixed_asc = '{32'hFF7FFFFF, 32'hC0000000, 32'hBF000000, 32'h0,
                      32'h0, 32'h3F000000, 32'h3F800000, 32'h40400000,
                      32'h40400000, 32'h7F7FFFFF};
        seq = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                32'h41100000, 32'h41200000};
        for (int e = 0; e < K; e++) rev[e] = seq[K-1-e];
        for (int e = 0; e < K; e++) ones[e] = 32'h3F800000;

        b10.start_sort = 1'b0; b10.Arr_in = '0;
        b1.start_sort  = 1'b0; b1.Arr_in  = '0;
        b2.start_sort  = 1'b0; b2.Arr_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, b10.busy}, 32'd0);
        check("rst_fin", {31'd0, b10.finish_sort}, 32'd0);
        check("rst_arr", {31'd0, |b10.Arr_out}, 32'd0);
        rst_n = 1'b1;

        // mixed values incl. signed zeros, extremes and a duplicate
        sort10(mixed, ones, 1'b0, "mixed", cyc);
        for (int p = 0; p < K; p++)
            if (p != 3 && p != 4)
                check($sformatf("mixed_e%0d", pos(p)), el(pos(p)), mixed_asc[p]);
        x = el(pos(3));
        y = el(pos(4));
        check("mixed_zero_pair",
              {31'd0, (x == 32'h0 && y == 32'h80000000) ||
                      (x == 32'h80000000 && y == 32'h0)}, 32'd1);

        sort10(seq, ones, 1'b0, "sorted", cyc);
        check_plain(seq, "sorted");
        check("sorted_bound", {31'd0, cyc <= 89}, 32'd1);

        sort10(rev, ones, 1'b0, "rev", cyc);
        check_plain(seq, "rev");
        check("rev_bound", {31'd0, cyc <= 89}, 32'd1);

        sort10(ones, ones, 1'b0, "equal", cyc);
        check_plain(ones, "equal");

        // new start mid-sort must be ignored
        sort10(seq, ones, 1'b1, "ignore", cyc);
        check_plain(seq, "ignore");

        // reset mid-sort: aborts with no result flagged
        @(posedge clk); #1;
        b10.Arr_in = pack(mixed);
        b10.start_sort = 1'b1;
        @(posedge clk); #1;
        b10.start_sort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, b10.busy}, 32'd0);
        check("abort_fin", {31'd0, b10.finish_sort}, 32'd0);
        check("abort_arr", {31'd0, |b10.Arr_out}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk); #1;
            if (b10.finish_sort) pulses++;
        end
        check("abort_nopulse", pulses, 32'd0);

        // K=1: finish two cycles after the start is presented
        b1.Arr_in = 32'hC0490FDB;
        b1.start_sort = 1'b1;
        @(posedge clk); #1;
        b1.start_sort = 1'b0;
        cyc = 1;
        while (!b1.finish_sort && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("k1_latency", cyc, 32'd2);
        check("k1_fin", {31'd0, b1.finish_sort}, 32'd1);
        check("k1_arr", b1.Arr_out, 32'hC0490FDB);

        // K=2 swap
        b2.Arr_in = {32'h3F800000, 32'h40000000};
        b2.start_sort = 1'b1;
        @(posedge clk); #1;
        b2.start_sort = 1'b0;
        cyc = 1;
        while (!b2.finish_sort && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("k2_fin", {31'd0, b2.finish_sort}, 32'd1);
        check("k2_e0", b2.Arr_out[31:0], DESC ? 32'h40000000 : 32'h3F800000);
        check("k2_e1", b2.Arr_out[63:32], DESC ? 32'h3F800000 : 32'h40000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
